// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the CPU execution-rate controller: state codes,
// default timing parameters and a counter-width helper.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STEP   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    localparam int unsigned DIV_SLOW_DEFAULT        = 25_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500_000;

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on every debounced 0->1 transition.
module btn_debounce
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_dly_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // NOTE: defaults first so every path assigns cnt_d/level_d; a path that
    // left either unassigned would infer a latch.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: non-blocking assignments so each flop samples its neighbours'
    // pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            rise_q      <= level_q & ~level_dly_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution-rate controller: issues single-cycle core enables in turbo,
// slow-divided or single-step mode, halts on request, counts enables.
module cpu_step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DIV_SLOW        = DIV_SLOW_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        turbo_mode,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        halt_req,
    output logic        cpu_en,
    output logic [1:0]  state_o,
    output logic [15:0] instr_cnt
);

    localparam int unsigned   DW       = cnt_width(DIV_SLOW);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_SLOW - 1);

    logic          turbo_s1_q;
    logic          turbo_s2_q;
    logic          run_s1_q;
    logic          run_s2_q;
    logic          step_pulse;
    logic          unused_btn_level;

    state_e        state_q;
    logic [DW-1:0] div_q;
    logic          cpu_en_q;
    logic [15:0]   instr_cnt_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_btn (
        .clk    (clk),
        .resetn (resetn),
        .raw    (step_btn),
        .level  (unused_btn_level),
        .rise   (step_pulse)
    );

    // Enable and divider default to idle each cycle; only the branch that
    // issues an enable or advances the slow divider overrides them, which
    // also gives halt_req and mode changes priority over enable generation.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            turbo_s1_q  <= 1'b0;
            turbo_s2_q  <= 1'b0;
            run_s1_q    <= 1'b0;
            run_s2_q    <= 1'b0;
            state_q     <= ST_STEP;
            div_q       <= '0;
            cpu_en_q    <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            turbo_s1_q  <= turbo_mode;
            turbo_s2_q  <= turbo_s1_q;
            run_s1_q    <= run_sw;
            run_s2_q    <= run_s1_q;
            cpu_en_q    <= 1'b0;
            div_q       <= '0;
            instr_cnt_q <= instr_cnt_q + 16'(cpu_en_q);

            unique case (state_q)
                ST_STEP: begin
                    if (halt_req) begin
                        state_q <= ST_HALTED;
                    end else if (run_s2_q) begin
                        state_q <= ST_RUN;
                    end else if (step_pulse) begin
                        cpu_en_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_q <= ST_HALTED;
                    end else if (!run_s2_q) begin
                        state_q <= ST_STEP;
                    end else if (turbo_s2_q) begin
                        cpu_en_q <= 1'b1;
                    end else if (div_q == DIV_LAST) begin
                        cpu_en_q <= 1'b1;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                ST_HALTED: begin
                    if (step_pulse) begin
                        state_q <= run_s2_q ? ST_RUN : ST_STEP;
                    end
                end
                default: state_q <= ST_STEP;
            endcase
        end
    end

    assign cpu_en    = cpu_en_q;
    assign state_o   = state_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: directed scenarios with literal
// expectations plus randomized stimulus compared against a behavioural model.
module tb_cpu_step_ctrl;

    localparam int DIV = 4;
    localparam int DB  = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        turbo_mode;
    logic        run_sw;
    logic        step_btn;
    logic        halt_req;
    logic        cpu_en;
    logic [1:0]  state_o;
    logic [15:0] instr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    cpu_step_ctrl #(
        .DIV_SLOW        (DIV),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .turbo_mode (turbo_mode),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .halt_req   (halt_req),
        .cpu_en     (cpu_en),
        .state_o    (state_o),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model. States use the output codes: 0 STEP, 1 RUN, 2 HALTED.
    // Synchronized inputs are the raw samples from two edges back; the
    // debounced level flips once the last DB synced samples all disagree
    // with it; a press is reported one edge after the level rises.
    bit          m_valid = 1'b0;
    int unsigned m_state, m_cnt, m_phase;
    bit          m_en, m_level, m_rose, m_pulse;
    bit          q_turbo[$], q_run[$], q_btn[$], q_deb[$];

    task automatic model_step();
        bit          s_turbo, s_run, s_btn, n_en, n_pulse, all_diff;
        int unsigned n_state, n_phase;
        if (!resetn) begin
            m_state = 0; m_cnt = 0; m_phase = 0;
            m_en = 0; m_level = 0; m_rose = 0; m_pulse = 0;
            q_turbo = '{0, 0}; q_run = '{0, 0}; q_btn = '{0, 0};
            q_deb.delete();
            m_valid = 1'b1;
            return;
        end
        s_turbo = q_turbo[0];
        s_run   = q_run[0];
        s_btn   = q_btn[0];

        n_state = m_state;
        n_en    = 1'b0;
        n_phase = 0;
        case (m_state)
            0: begin
                if (halt_req)   n_state = 2;
                else if (s_run) n_state = 1;
                else            n_en = m_pulse;
            end
            1: begin
                if (halt_req)     n_state = 2;
                else if (!s_run)  n_state = 0;
                else if (s_turbo) n_en = 1'b1;
                else begin
                    n_phase = (m_phase + 1) % DIV;
                    n_en    = (n_phase == 0);
                end
            end
            default: if (m_pulse) n_state = s_run ? 1 : 0;
        endcase

        q_deb.push_back(s_btn);
        if (q_deb.size() > DB) void'(q_deb.pop_front());
        all_diff = (q_deb.size() == DB);
        foreach (q_deb[i]) if (q_deb[i] == m_level) all_diff = 1'b0;
        n_pulse = m_rose;
        m_rose  = all_diff && !m_level;
        if (all_diff) m_level = !m_level;

        m_cnt   = (m_cnt + (m_en ? 1 : 0)) % 65536;
        m_en    = n_en;
        m_state = n_state;
        m_phase = n_phase;
        m_pulse = n_pulse;

        q_turbo.push_back(turbo_mode); void'(q_turbo.pop_front());
        q_run.push_back(run_sw);       void'(q_run.pop_front());
        q_btn.push_back(step_btn);     void'(q_btn.pop_front());
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("cpu_en vs model", 32'(cpu_en), 32'(m_en));
            check("state_o vs model", 32'(state_o), m_state);
            check("instr_cnt vs model", 32'(instr_cnt), m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        resetn = 1'b0; turbo_mode = 1'b0; run_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
        tick();
        tick();
        check("reset cpu_en", 32'(cpu_en), 32'd0);
        check("reset state_o", 32'(state_o), 32'd0);
        check("reset instr_cnt", 32'(instr_cnt), 32'd0);
        resetn = 1'b1;
    endtask

    initial begin
        int          n_en;
        int          first_k;
        int          cyc;
        logic [31:0] mask;

        // Step with bounce: final rising sample at edge F, enable set at F+6.
        do_reset();
        step_btn = 1'b1; tick();
        step_btn = 1'b0; tick();
        step_btn = 1'b1;
        n_en = 0; first_k = -1;
        for (int k = 0; k < 13; k++) begin
            tick();
            if (cpu_en) begin
                n_en++;
                if (first_k < 0) first_k = k;
            end
        end
        check("step pulse count", 32'(n_en), 32'd1);
        check("step latency", 32'(first_k), 32'd6);
        check("step instr_cnt", 32'(instr_cnt), 32'd1);
        check("model step count", m_cnt, 32'd1);
        step_btn = 1'b0;
        repeat (8) tick();

        // Slow run, then halt coinciding with divider = DIV-1.
        do_reset();
        run_sw = 1'b1;
        tick(); tick();
        check("mode switch after 2 edges", 32'(state_o), 32'd0);
        tick();
        check("mode switch after 3 edges", 32'(state_o), 32'd1);
        mask = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (cpu_en) mask[k] = 1'b1;
        end
        check("slow run enable cycles", mask, 32'h0011_1110);
        tick();
        check("slow instr_cnt", 32'(instr_cnt), 32'd5);
        check("model slow count", m_cnt, 32'd5);
        tick(); tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        check("tie cpu_en", 32'(cpu_en), 32'd0);
        check("tie state_o", 32'(state_o), 32'd2);
        n_en = 0;
        repeat (6) begin tick(); n_en += int'(cpu_en); end
        check("tie no later enable", 32'(n_en), 32'd0);

        // Turbo run, then turbo off, then halt and resume.
        do_reset();
        turbo_mode = 1'b1; run_sw = 1'b1;
        tick(); tick(); tick();
        check("turbo entered RUN", 32'(state_o), 32'd1);
        check("turbo entry no enable", 32'(cpu_en), 32'd0);
        n_en = 0;
        repeat (10) begin tick(); n_en += int'(cpu_en); end
        check("turbo enables", 32'(n_en), 32'd10);
        turbo_mode = 1'b0;
        mask = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (cpu_en) mask[k] = 1'b1;
        end
        check("turbo to slow", mask, 32'h0000_0046);
        turbo_mode = 1'b1;
        repeat (4) tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        check("halt state_o", 32'(state_o), 32'd2);
        check("halt cpu_en", 32'(cpu_en), 32'd0);
        n_en = 0;
        repeat (5) begin tick(); n_en += int'(cpu_en); end
        check("halted no enable", 32'(n_en), 32'd0);
        step_btn = 1'b1;
        cyc = 0;
        do begin tick(); cyc++; end while (state_o == 2'd2 && cyc < 30);
        check("resume latency", 32'(cyc), 32'd7);
        check("resume state_o", 32'(state_o), 32'd1);
        check("resume exit no enable", 32'(cpu_en), 32'd0);
        tick();
        check("resume turbo enable", 32'(cpu_en), 32'd1);
        step_btn = 1'b0;
        repeat (10) tick();

        // Counter wrap, then reset mid-run.
        do_reset();
        turbo_mode = 1'b1; run_sw = 1'b1;
        for (int i = 0; i < 70000 && instr_cnt != 16'hFFFF; i++) tick();
        check("wrap preload", 32'(instr_cnt), 32'h0000_FFFF);
        tick();
        check("wrap to zero", 32'(instr_cnt), 32'd0);
        check("model wrap", m_cnt, 32'd0);
        check("pre-reset enable", 32'(cpu_en), 32'd1);
        resetn = 1'b0; tick();
        check("mid-run reset cpu_en", 32'(cpu_en), 32'd0);
        check("mid-run reset state_o", 32'(state_o), 32'd0);
        check("mid-run reset instr_cnt", 32'(instr_cnt), 32'd0);
        resetn = 1'b1;

        // Randomized traffic; the compare process checks every cycle.
        begin
            int hold = 0;
            run_sw = 1'b0; turbo_mode = 1'b0;
            for (int i = 0; i < 8000; i++) begin
                if (hold == 0) begin
                    step_btn = 1'($urandom_range(0, 1));
                    hold     = int'($urandom_range(1, 10));
                end
                hold--;
                if ($urandom_range(0, 99) == 0) run_sw = ~run_sw;
                if ($urandom_range(0, 49) == 0) turbo_mode = ~turbo_mode;
                halt_req = ($urandom_range(0, 59) == 0);
                resetn   = ($urandom_range(0, 1999) != 0);
                tick();
            end
        end
        halt_req = 1'b0; resetn = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
